// File: rtl/rv_dispatch_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_dispatch_queue_pkg: execution-unit codes and default geometry   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rv_dispatch_queue_pkg;

  localparam int EX_BITS = 3;

  localparam logic [EX_BITS-1:0] EX_ALU = 3'd0;
  localparam logic [EX_BITS-1:0] EX_LSU = 3'd1;
  localparam logic [EX_BITS-1:0] EX_CSR = 3'd2;
  localparam logic [EX_BITS-1:0] EX_FPU = 3'd3;
  localparam logic [EX_BITS-1:0] EX_GPU = 3'd4;

  localparam int NUM_UNITS_DEF = int'(EX_GPU) + 1;
  localparam int DATAW_DEF     = 64;
  localparam int DEPTH_DEF     = 4;
  localparam int CNT_W_DEF     = 16;

endpackage
`default_nettype wire

// File: rtl/rv_dispatch_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_dispatch_queue_if: upstream issue port and per-unit channels    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface rv_dispatch_queue_if
  import rv_dispatch_queue_pkg::*;
#(
  parameter int NUM_UNITS = NUM_UNITS_DEF,
  parameter int EX_BITS   = rv_dispatch_queue_pkg::EX_BITS,
  parameter int DATAW     = DATAW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                       flush;
  logic                       in_valid;
  logic [EX_BITS-1:0]         in_ex_type;
  logic [DATAW-1:0]           in_data;
  logic                       in_ready;
  logic [NUM_UNITS-1:0]       out_valid;
  logic [NUM_UNITS*DATAW-1:0] out_data;
  logic [NUM_UNITS-1:0]       out_ready;
  logic [NUM_UNITS*OCC_W-1:0] occupancy;
  logic                       bad_type;
  logic [CNT_W-1:0]           stall_cycles;
  logic                       all_empty;

  modport master (
    output flush, in_valid, in_ex_type, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, bad_type, stall_cycles, all_empty
  );

  modport slave (
    input  flush, in_valid, in_ex_type, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, bad_type, stall_cycles, all_empty
  );

endinterface
`default_nettype wire

// File: rtl/rv_dispatch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_dispatch_fifo: DEPTH-entry per-channel FIFO with flush          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rv_dispatch_fifo #(
  parameter int DATAW = 64,
  parameter int DEPTH = 4
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  input  wire logic                          push,
  input  wire logic                          pop,
  input  wire logic                          flush,
  input  wire logic [DATAW-1:0]              data_in,
  output logic      [DATAW-1:0]              data_out,
  output logic                               full,
  output logic                               empty,
  output logic      [$clog2(DEPTH+1)-1:0]    count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = mem_q[rd_ptr_q];
  assign full     = (count_q == OCC_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/rv_dispatch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_dispatch_queue: routes issued payloads to per-unit FIFOs        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rv_dispatch_queue
  import rv_dispatch_queue_pkg::*;
#(
  parameter int NUM_UNITS = NUM_UNITS_DEF,
  parameter int EX_BITS   = rv_dispatch_queue_pkg::EX_BITS,
  parameter int DATAW     = DATAW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  wire logic         clk,
  input  wire logic         reset,
  rv_dispatch_queue_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  logic [NUM_UNITS-1:0]            fifo_full;
  logic [NUM_UNITS-1:0]            fifo_empty;
  logic [NUM_UNITS-1:0]            fifo_push;
  logic [NUM_UNITS-1:0]            fifo_pop;
  logic [NUM_UNITS-1:0][OCC_W-1:0] fifo_count;
  logic [NUM_UNITS-1:0][DATAW-1:0] fifo_dout;

  logic             in_range;
  logic             sel_full;
  logic             accept;
  logic             bad_type_q, bad_type_d;
  logic [CNT_W-1:0] stall_q,    stall_d;

  assign in_range = (32'(bus.in_ex_type) < NUM_UNITS);

  always_comb begin
    sel_full = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (32'(bus.in_ex_type) == k) sel_full = fifo_full[k];
    end
  end

  // Ready looks only at registered fullness, never at out_ready.
  assign bus.in_ready = reset && !bus.flush && (in_range ? !sel_full : 1'b1);
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_chan
    assign fifo_push[k] = accept && (32'(bus.in_ex_type) == k);
    assign fifo_pop[k]  = bus.out_valid[k] && bus.out_ready[k];

    rv_dispatch_fifo #(
      .DATAW (DATAW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push[k]),
      .pop      (fifo_pop[k]),
      .flush    (bus.flush),
      .data_in  (bus.in_data),
      .data_out (fifo_dout[k]),
      .full     (fifo_full[k]),
      .empty    (fifo_empty[k]),
      .count    (fifo_count[k])
    );
  end

  always_comb begin
    bad_type_d = accept && !in_range;
    stall_d    = stall_q;
    if (bus.in_valid && !bus.in_ready && !bus.flush && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bad_type_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      bad_type_q <= bad_type_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.out_valid    = ~fifo_empty & {NUM_UNITS{!bus.flush}};
  assign bus.out_data     = fifo_dout;
  assign bus.occupancy    = fifo_count;
  assign bus.all_empty    = &fifo_empty;
  assign bus.bad_type     = bad_type_q;
  assign bus.stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_dispatch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rv_dispatch_queue: directed checks for rv_dispatch_queue        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rv_dispatch_queue;

  localparam int NUM_UNITS = 5;
  localparam int DATAW     = 64;
  localparam int OCC_W     = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv_dispatch_queue_if #(.NUM_UNITS(NUM_UNITS), .EX_BITS(3), .DATAW(DATAW),
                         .DEPTH(4), .CNT_W(16)) bus ();

  rv_dispatch_queue #(.NUM_UNITS(NUM_UNITS), .EX_BITS(3), .DATAW(DATAW),
                      .DEPTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [OCC_W-1:0] occ(int k);
    return bus.occupancy[k*OCC_W +: OCC_W];
  endfunction

  function automatic logic [DATAW-1:0] head(int k);
    return bus.out_data[k*DATAW +: DATAW];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [2:0] t, logic [63:0] d);
    bus.in_valid   = v;
    bus.in_ex_type = t;
    bus.in_data    = d;
  endtask

  initial begin
    logic [63:0] exp_q [2];
    reset         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = '0;
    drive(1'b1, 3'd2, 64'h0);

    // Reset held low with in_valid asserted
    repeat (3) begin
      cyc();
      chk("rst_in_ready",  64'(bus.in_ready),     64'd0);
      chk("rst_out_valid", 64'(bus.out_valid),    64'd0);
      chk("rst_occupancy", 64'(bus.occupancy),    64'd0);
      chk("rst_stall",     64'(bus.stall_cycles), 64'd0);
    end
    drive(1'b0, 3'd0, 64'h0);
    reset = 1'b1;
    cyc();
    chk("idle_all_empty", 64'(bus.all_empty), 64'd1);

    // Fill channel 2 and hold the fifth entry under backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd2, 64'h11 + 64'(i));
      #1;
      chk("fill_in_ready", 64'(bus.in_ready), 64'd1);
      cyc();
    end
    chk("fill_occ2",      64'(occ(2)),          64'd4);
    chk("fill_out_valid", 64'(bus.out_valid),   64'b00100);
    chk("fill_head2",     head(2),              64'h11);
    drive(1'b1, 3'd2, 64'h15);
    #1;
    chk("full_in_ready",  64'(bus.in_ready),    64'd0);
    cyc();
    chk("stall_1",        64'(bus.stall_cycles), 64'd1);
    cyc();
    chk("stall_2",        64'(bus.stall_cycles), 64'd2);
    bus.out_ready = 5'b00100;
    #1;
    chk("drain_head_11",  head(2),              64'h11);
    chk("drain_no_bypass", 64'(bus.in_ready),   64'd0);
    cyc();
    chk("stall_3",        64'(bus.stall_cycles), 64'd3);
    chk("drain_occ_3",    64'(occ(2)),          64'd3);
    chk("drain_head_12",  head(2),              64'h12);
    chk("drain_ready",    64'(bus.in_ready),    64'd1);
    cyc();
    drive(1'b0, 3'd0, 64'h0);
    chk("drain_occ_same", 64'(occ(2)),          64'd3);
    chk("drain_head_13",  head(2),              64'h13);
    exp_q[0] = 64'h14;
    exp_q[1] = 64'h15;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("drain_order",  head(2),              exp_q[i]);
    end
    cyc();
    chk("drain_empty",    64'(bus.out_valid),   64'd0);
    chk("stall_hold",     64'(bus.stall_cycles), 64'd3);
    bus.out_ready = '0;

    // Enqueue latency with a concurrent dequeue on channel 1
    drive(1'b1, 3'd1, 64'h77);
    cyc();
    chk("pre_occ1",       64'(occ(1)),          64'd1);
    drive(1'b1, 3'd0, 64'hA5);
    bus.out_ready = 5'b00010;
    #1;
    chk("lat_not_yet",    64'(bus.out_valid[0]), 64'd0);
    cyc();
    drive(1'b0, 3'd0, 64'h0);
    bus.out_ready = '0;
    chk("lat_valid0",     64'(bus.out_valid[0]), 64'd1);
    chk("lat_data0",      head(0),              64'hA5);
    chk("lat_occ1",       64'(occ(1)),          64'd0);
    bus.out_ready = 5'b00001;
    cyc();
    bus.out_ready = '0;
    chk("lat_cleared",    64'(bus.all_empty),   64'd1);

    // Wrap-around on channel 3: steady one-in/one-out
    drive(1'b1, 3'd3, 64'h30);
    cyc();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 3'd3, 64'h30 + 64'(i));
      bus.out_ready = 5'b01000;
      #1;
      chk("wrap_head",    head(3),              64'h30 + 64'(i - 1));
      cyc();
      chk("wrap_occ3",    64'(occ(3)),          64'd1);
    end
    drive(1'b0, 3'd0, 64'h0);
    chk("wrap_last",      head(3),              64'h3A);
    cyc();
    bus.out_ready = '0;
    chk("wrap_empty",     64'(bus.all_empty),   64'd1);

    // Out-of-range type is accepted and dropped
    drive(1'b1, 3'd6, 64'hDEAD);
    #1;
    chk("bad_in_ready",   64'(bus.in_ready),    64'd1);
    chk("bad_pre",        64'(bus.bad_type),    64'd0);
    cyc();
    drive(1'b0, 3'd0, 64'h0);
    chk("bad_pulse",      64'(bus.bad_type),    64'd1);
    chk("bad_occ",        64'(bus.occupancy),   64'd0);
    cyc();
    chk("bad_once",       64'(bus.bad_type),    64'd0);

    // Flush with channels 0 and 4 partially filled
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 64'h40 + 64'(i));
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd4, 64'h50 + 64'(i));
      cyc();
    end
    chk("fl_pre_occ",     64'(bus.occupancy),   64'h2003);
    drive(1'b1, 3'd0, 64'h99);
    bus.flush     = 1'b1;
    bus.out_ready = '1;
    #1;
    chk("fl_in_ready",    64'(bus.in_ready),    64'd0);
    chk("fl_out_valid",   64'(bus.out_valid),   64'd0);
    cyc();
    bus.flush     = 1'b0;
    bus.out_ready = '0;
    drive(1'b0, 3'd0, 64'h0);
    chk("fl_all_empty",   64'(bus.all_empty),   64'd1);
    chk("fl_occ",         64'(bus.occupancy),   64'd0);
    chk("fl_stall",       64'(bus.stall_cycles), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
